// File: rtl/fir.sv
// rtl/fir.sv - fixed-coefficient 8-tap direct-form FIR, one sample per clock
module fir #(
  parameter int N_TAPS = 8,
  parameter int DW = 32,
  parameter int CW = 16,
  parameter logic signed [CW-1:0] H0 = 1,
  parameter logic signed [CW-1:0] H1 = 2,
  parameter logic signed [CW-1:0] H2 = 3,
  parameter logic signed [CW-1:0] H3 = 4,
  parameter logic signed [CW-1:0] H4 = 4,
  parameter logic signed [CW-1:0] H5 = 3,
  parameter logic signed [CW-1:0] H6 = 2,
  parameter logic signed [CW-1:0] H7 = 1
) (
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y,
  input  logic          clk,
  input  logic          rst_n
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + 3;

  localparam logic signed [CW-1:0] COEF [8] = '{H0, H1, H2, H3, H4, H5, H6, H7};

  logic [DW-1:0] d [N_TAPS];
  logic [DW-1:0] tap [N_TAPS];
  logic signed [PW-1:0] prod [N_TAPS];
  logic signed [AW-1:0] acc;

  // tap[0] is the live input so the newest sample reaches y at its own edge
  always_comb begin
    tap[0] = x;
    for (int i = 1; i < N_TAPS; i++) begin
      tap[i] = d[i-1];
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      prod[i] = $signed({{CW{tap[i][DW-1]}}, tap[i]}) *
                $signed({{DW{COEF[i][CW-1]}}, COEF[i]});
      acc = acc + $signed({{(AW-PW){prod[i][PW-1]}}, prod[i]});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        d[i] <= '0;
      end
      y <= '0;
    end else begin
      d[0] <= x;
      for (int i = 1; i < N_TAPS; i++) begin
        d[i] <= d[i-1];
      end
      y <= acc[DW-1:0];
    end
  end

endmodule

// File: tb/tb_fir.sv
// tb/tb_fir.sv - self-checking bench for fir: spec vector table, reset cases, random model
module tb_fir;

  logic [31:0] x;
  logic [31:0] y;
  logic        clk;
  logic        rst_n;

  fir dut (
    .x     (x),
    .y     (y),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic [31:0] xin;
    logic [31:0] yexp;
  } vec_t;

  int n_vec;
  int n_bad;
  logic [31:0] sb [$];
  int hist [7];
  int coef [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: y=0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] v);
    longint acc;
    acc = longint'(coef[0]) * longint'($signed(v));
    for (int i = 1; i < 8; i++) acc += longint'(coef[i]) * longint'(hist[i-1]);
    return acc[31:0];
  endfunction

  // called at posedge+1; drives x, then samples y #1 after the next edge
  task automatic drive(input string name, input logic [31:0] v, input logic [31:0] exp);
    logic [31:0] e;
    x = v;
    sb.push_back(exp);
    for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = $signed(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, y=0x%08h", name, y);
    end else begin
      e = sb.pop_front();
      check(name, y, e);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 7; i++) hist[i] = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    x = 32'd123;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", y, 32'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic add(input logic r, input logic [31:0] v, input logic [31:0] e);
    vec_t t;
    t.rst_before = r;
    t.xin = v;
    t.yexp = e;
    tbl.push_back(t);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    x = '0;
    rst_n = 1'b0;
    clear_model();

    // impulse
    add(1'b1, 32'd1, 32'd1);
    add(1'b0, 32'd0, 32'd2);
    add(1'b0, 32'd0, 32'd3);
    add(1'b0, 32'd0, 32'd4);
    add(1'b0, 32'd0, 32'd4);
    add(1'b0, 32'd0, 32'd3);
    add(1'b0, 32'd0, 32'd2);
    add(1'b0, 32'd0, 32'd1);
    add(1'b0, 32'd0, 32'd0);
    add(1'b0, 32'd0, 32'd0);
    // step
    add(1'b1, 32'd10, 32'd10);
    add(1'b0, 32'd10, 32'd30);
    add(1'b0, 32'd10, 32'd60);
    add(1'b0, 32'd10, 32'd100);
    add(1'b0, 32'd10, 32'd140);
    add(1'b0, 32'd10, 32'd170);
    add(1'b0, 32'd10, 32'd190);
    add(1'b0, 32'd10, 32'd200);
    add(1'b0, 32'd10, 32'd200);
    add(1'b0, 32'd10, 32'd200);
    // negative impulse
    add(1'b1, 32'hFFFFFFFB, 32'hFFFFFFFB);
    add(1'b0, 32'd0, 32'hFFFFFFF6);
    add(1'b0, 32'd0, 32'hFFFFFFF1);
    add(1'b0, 32'd0, 32'hFFFFFFEC);
    add(1'b0, 32'd0, 32'hFFFFFFEC);
    add(1'b0, 32'd0, 32'hFFFFFFF1);
    add(1'b0, 32'd0, 32'hFFFFFFF6);
    add(1'b0, 32'd0, 32'hFFFFFFFB);
    add(1'b0, 32'd0, 32'd0);
    // wrap: k*(2^31-1) mod 2^32 for k = 1,3,6,10,14,17,19,20
    add(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF);
    add(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFD);
    add(1'b0, 32'h7FFFFFFF, 32'hFFFFFFFA);
    add(1'b0, 32'h7FFFFFFF, 32'hFFFFFFF6);
    add(1'b0, 32'h7FFFFFFF, 32'hFFFFFFF2);
    add(1'b0, 32'h7FFFFFFF, 32'h7FFFFFEF);
    add(1'b0, 32'h7FFFFFFF, 32'h7FFFFFED);
    add(1'b0, 32'h7FFFFFFF, 32'hFFFFFFEC);
    add(1'b0, 32'h7FFFFFFF, 32'hFFFFFFEC);
    add(1'b0, 32'h7FFFFFFF, 32'hFFFFFFEC);

    #2;
    check("reset_initial", y, 32'h0);

    foreach (tbl[k]) begin
      if (tbl[k].rst_before) do_reset();
      drive($sformatf("vec%0d", k), tbl[k].xin, tbl[k].yexp);
    end

    // mid-stream asynchronous reset
    do_reset();
    drive("mid_step0", 32'd10, 32'd10);
    drive("mid_step1", 32'd10, 32'd30);
    drive("mid_step2", 32'd10, 32'd60);
    drive("mid_step3", 32'd10, 32'd100);
    drive("mid_step4", 32'd10, 32'd140);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("async_reset", y, 32'h0);
    @(posedge clk);
    #1;
    check("async_reset_hold", y, 32'h0);
    rst_n = 1'b1;
    drive("resume0", 32'd10, 32'd10);
    drive("resume1", 32'd10, 32'd30);
    drive("resume2", 32'd10, 32'd60);

    // random stream against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] v;
      v = (i % 3 == 0) ? $urandom() : $urandom_range(0, 2000) - 1000;
      drive($sformatf("rand%0d", i), v, model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
